// File: rtl/sprite_line_render_if.sv
// Attribute RAM and sprite ROM bus between the line renderer (master) and its memories (slave).
interface sprite_line_render_if;
  logic [7:0]  spr_addr;
  logic [7:0]  spr_data;
  logic [12:0] rom_addr;
  logic        rom_req;
  logic        rom_ack;
  logic [15:0] rom_data;

  modport master (output spr_addr, rom_addr, rom_req,
                  input  spr_data, rom_ack, rom_data);
  modport slave  (input  spr_addr, rom_addr, rom_req,
                  output spr_data, rom_ack, rom_data);
endinterface

// File: rtl/sprite_line_render.sv
// Per-scanline sprite engine: scans attributes for the next line into a back line buffer
// while streaming (and clearing) the front buffer to the colour mixer.
module sprite_line_render #(
  parameter int NSPR   = 64,
  parameter int HTOTAL = 384,
  parameter int VTOTAL = 263,
  parameter int HSTART = 4,
  parameter int HWIDTH = 240
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic                 ce_pix,
  input  logic [8:0]           hcount,
  input  logic [8:0]           vcount,
  sprite_line_render_if.master bus,
  output logic [5:0]           pix_out
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_ATTR  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_FETCH = 3'd4;
  localparam logic [2:0] S_DRAW  = 3'd5;
  localparam logic [2:0] S_NEXT  = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] code;
    logic       flipy;
    logic       flipx;
    logic [3:0] color;
    logic [7:0] x;
  } attr_t;

  logic [2:0]  state;
  logic        sel;
  logic [7:0]  tgt;
  logic [5:0]  n;
  logic [2:0]  bc;
  attr_t       attr;
  logic [3:0]  row;
  logic        half;
  logic        second;
  logic [15:0] pat;
  logic [2:0]  i;

  logic [5:0] lb0 [256];
  logic [5:0] lb1 [256];

  logic       swap, vis, hit, draw_we;
  logic [7:0] ridx, rdiff;
  logic [5:0] front, dval;
  logic [2:0] s;
  logic [1:0] dpix, back_lo;
  logic [8:0] dx9;

  assign swap  = ce_pix && (hcount == 9'(HTOTAL-1));
  assign vis   = ce_pix && (hcount >= 9'(HSTART)) && (hcount < 9'(HSTART+HWIDTH));
  assign ridx  = 8'(hcount - 9'(HSTART));
  assign front = sel ? lb1[ridx] : lb0[ridx];

  assign rdiff = tgt - attr.y;
  assign hit   = (rdiff < 8'd16);

  // second pass draws the right half of the sprite in display order
  assign s       = attr.flipx ? ~i : i;
  assign dpix    = {pat[{1'b1, s}], pat[{1'b0, s}]};
  assign dx9     = {1'b0, attr.x} + {5'd0, second, 3'd0} + {6'd0, i};
  assign back_lo = sel ? lb0[dx9[7:0]][1:0] : lb1[dx9[7:0]][1:0];
  assign draw_we = (state == S_DRAW) && (dpix != 2'd0) && !dx9[8] && (back_lo == 2'd0);
  assign dval    = {attr.color, dpix};

  // front is only cleared by readout, back only written by DRAW: one port per buffer per role
  always_ff @(posedge clk_sys) begin
    if (vis) begin
      if (sel) lb1[ridx] <= '0;
      else     lb0[ridx] <= '0;
    end
    if (draw_we) begin
      if (sel) lb0[dx9[7:0]] <= dval;
      else     lb1[dx9[7:0]] <= dval;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)    pix_out <= '0;
    else if (ce_pix) pix_out <= vis ? front : 6'd0;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      sel          <= 1'b0;
      tgt          <= '0;
      n            <= '0;
      bc           <= '0;
      attr         <= '0;
      row          <= '0;
      half         <= 1'b0;
      second       <= 1'b0;
      pat          <= '0;
      i            <= '0;
      bus.spr_addr <= '0;
      bus.rom_addr <= '0;
      bus.rom_req  <= 1'b0;
    end else if (swap) begin
      // a request still outstanding is abandoned; its ack lands outside FETCH or before req rises
      sel         <= ~sel;
      state       <= S_START;
      bus.rom_req <= 1'b0;
      tgt         <= (vcount == 9'(VTOTAL-1)) ? 8'd0 : 8'(vcount + 9'd1);
    end else begin
      case (state)
        S_IDLE, S_DONE: ;
        S_START: begin
          n            <= '0;
          bc           <= '0;
          bus.spr_addr <= '0;
          state        <= S_ATTR;
        end
        S_ATTR: begin
          // byte k arrives one clock after its address, hence the 5th cycle
          case (bc)
            3'd1: attr.y    <= bus.spr_data;
            3'd2: attr.code <= bus.spr_data;
            3'd3: {attr.flipy, attr.flipx, attr.color} <=
                    {bus.spr_data[7:6], bus.spr_data[3:0]};
            3'd4: attr.x    <= bus.spr_data;
            default: ;
          endcase
          if (bc < 3'd3) bus.spr_addr <= {n, bc[1:0] + 2'd1};
          bc <= bc + 3'd1;
          if (bc == 3'd4) state <= S_CHECK;
        end
        S_CHECK: begin
          if (hit) begin
            row    <= rdiff[3:0] ^ {4{attr.flipy}};
            half   <= attr.flipx;
            second <= 1'b0;
            state  <= S_FETCH;
          end else begin
            state  <= S_NEXT;
          end
        end
        S_FETCH: begin
          if (!bus.rom_req) begin
            bus.rom_req  <= 1'b1;
            bus.rom_addr <= {attr.code, row, half};
          end else if (bus.rom_ack) begin
            pat         <= bus.rom_data;
            bus.rom_req <= 1'b0;
            i           <= '0;
            state       <= S_DRAW;
          end
        end
        S_DRAW: begin
          i <= i + 3'd1;
          if (i == 3'd7) begin
            if (!second) begin
              second <= 1'b1;
              half   <= ~half;
              state  <= S_FETCH;
            end else begin
              state  <= S_NEXT;
            end
          end
        end
        S_NEXT: begin
          if (n == 6'(NSPR-1)) begin
            state <= S_DONE;
          end else begin
            n            <= n + 6'd1;
            bc           <= '0;
            bus.spr_addr <= {n + 6'd1, 2'b00};
            state        <= S_ATTR;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
